// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 message padder and block sequencer.
// Turns a 32-bit valid/ready word stream into 512-bit sha256 blocks.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   sha224_mode_i        digest mode, sampled on the first beat
//   s_data_i, s_bytes_i, s_last_i, s_valid_i, s_ready_o
//                        message word stream, first byte in [31:24]
//   core_ready_i, core_digest_valid_i
//                        status from the sha256 core
//   block_o, init_o, next_o, mode_o
//                        block and start pulses to the core
//   msg_done_o           digest of the final block is valid
//   busy_o               a message is in progress
module sha256_padder #(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sha224_mode_i,
    input  logic [31:0]  s_data_i,
    input  logic [2:0]   s_bytes_i,
    input  logic         s_last_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic         core_ready_i,
    input  logic         core_digest_valid_i,
    output logic [511:0] block_o,
    output logic         init_o,
    output logic         next_o,
    output logic         mode_o,
    output logic         msg_done_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {FILL, PAD, ISSUE, WAIT} state_t;

    state_t           state, state_d;
    logic [511:0]     blk, blk_d;
    logic [3:0]       wcnt, wcnt_d;
    logic [LEN_W-1:0] count, count_d;
    logic             first, first_d;
    logic             fin, fin_d;
    logic             pend80, pend80_d;
    logic             extra, extra_d;
    logic             mode, mode_d;
    logic             busy, busy_d;
    logic             init_q, init_d;
    logic             next_q, next_d;

    logic [3:0]  widx;
    logic [8:0]  wpos;
    logic [63:0] len_bits;
    logic        fits;
    logic        lenok;
    logic [31:0] in_word;
    logic [31:0] pad_word;

    // Keep the valid leading bytes, put 0x80 right after them.
    function automatic logic [31:0] mask_word(
        input logic [31:0] d,
        input logic [2:0]  n
    );
        case (n)
            3'd0:    mask_word = 32'h8000_0000;
            3'd1:    mask_word = {d[31:24], 24'h80_0000};
            3'd2:    mask_word = {d[31:16], 16'h8000};
            3'd3:    mask_word = {d[31:8], 8'h80};
            default: mask_word = d;
        endcase
    endfunction

    assign widx     = 4'd15 - wcnt;
    assign wpos     = {widx, 5'd0};
    assign len_bits = 64'({count, 3'b000});
    // Room for the length after the last data byte and its 0x80.
    assign fits     = count[5:0] <= 6'd55;
    // A pad-only block always carries the length.
    assign lenok    = extra | fits;
    assign in_word  = mask_word(s_data_i, s_bytes_i);

    always_comb begin
        state_d  = state;
        blk_d    = blk;
        wcnt_d   = wcnt;
        count_d  = count;
        first_d  = first;
        fin_d    = fin;
        pend80_d = pend80;
        extra_d  = extra;
        mode_d   = mode;
        busy_d   = busy;
        init_d   = 1'b0;
        next_d   = 1'b0;
        pad_word = 32'h0;
        unique case (state)
            FILL: begin
                if (s_valid_i) begin
                    if (!busy) mode_d = sha224_mode_i;
                    busy_d           = 1'b1;
                    blk_d[wpos +: 32] = in_word;
                    count_d          = count + LEN_W'(s_bytes_i);
                    wcnt_d           = wcnt + 4'd1;
                    pend80_d         = s_last_i && (s_bytes_i >= 3'd4);
                    if (wcnt == 4'd15) begin
                        // Block full: a last beat here leaves a pad-only block.
                        state_d = ISSUE;
                        fin_d   = 1'b0;
                        extra_d = s_last_i;
                    end else if (s_last_i) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                if (pend80) pad_word = 32'h8000_0000;
                if (lenok && wcnt == 4'd14) pad_word = len_bits[63:32];
                if (lenok && wcnt == 4'd15) pad_word = len_bits[31:0];
                pend80_d          = 1'b0;
                blk_d[wpos +: 32] = pad_word;
                wcnt_d            = wcnt + 4'd1;
                if (wcnt == 4'd15) begin
                    state_d = ISSUE;
                    fin_d   = lenok;
                    extra_d = !lenok;
                end
            end
            ISSUE: begin
                if (core_ready_i) begin
                    init_d  = first;
                    next_d  = !first;
                    first_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_digest_valid_i) begin
                    wcnt_d = 4'd0;
                    if (fin) begin
                        busy_d  = 1'b0;
                        first_d = 1'b1;
                        count_d = '0;
                        state_d = FILL;
                    end else begin
                        state_d = extra ? PAD : FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FILL;
            blk    <= '0;
            wcnt   <= '0;
            count  <= '0;
            first  <= 1'b1;
            fin    <= 1'b0;
            pend80 <= 1'b0;
            extra  <= 1'b0;
            mode   <= 1'b0;
            busy   <= 1'b0;
            init_q <= 1'b0;
            next_q <= 1'b0;
        end else begin
            state  <= state_d;
            blk    <= blk_d;
            wcnt   <= wcnt_d;
            count  <= count_d;
            first  <= first_d;
            fin    <= fin_d;
            pend80 <= pend80_d;
            extra  <= extra_d;
            mode   <= mode_d;
            busy   <= busy_d;
            init_q <= init_d;
            next_q <= next_d;
        end
    end

    assign s_ready_o  = state == FILL;
    assign block_o    = blk;
    assign init_o     = init_q;
    assign next_o     = next_q;
    assign mode_o     = mode;
    assign busy_o     = busy;
    assign msg_done_o = (state == WAIT) && core_digest_valid_i && fin;

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: scoreboard bench for sha256_padder with a
// behavioural core model (ready/digest_valid timing only).
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sha224_mode_i;
    logic [31:0]  s_data_i;
    logic [2:0]   s_bytes_i;
    logic         s_last_i;
    logic         s_valid_i;
    logic         s_ready_o;
    logic         core_ready_i;
    logic         core_digest_valid_i;
    logic [511:0] block_o;
    logic         init_o;
    logic         next_o;
    logic         mode_o;
    logic         msg_done_o;
    logic         busy_o;

    always #5 clk = ~clk;

    sha256_padder #(.LEN_W(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sha224_mode_i       (sha224_mode_i),
        .s_data_i            (s_data_i),
        .s_bytes_i           (s_bytes_i),
        .s_last_i            (s_last_i),
        .s_valid_i           (s_valid_i),
        .s_ready_o           (s_ready_o),
        .core_ready_i        (core_ready_i),
        .core_digest_valid_i (core_digest_valid_i),
        .block_o             (block_o),
        .init_o              (init_o),
        .next_o              (next_o),
        .mode_o              (mode_o),
        .msg_done_o          (msg_done_o),
        .busy_o              (busy_o)
    );

    typedef struct {
        logic [511:0] blk;
        bit           first;
        bit           mode;
    } exp_t;

    exp_t         exp_q[$];
    logic [511:0] blk_log[$];
    byte unsigned msg[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           pulses = 0;
    int           done_cnt = 0;
    int           done_exp = 0;

    // Core model: drops ready on a start pulse, returns digest later.
    logic core_rdy;
    logic core_dv;
    logic hold = 1'b0;
    int   ccnt;

    assign core_ready_i        = core_rdy & ~hold;
    assign core_digest_valid_i = core_dv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rdy <= 1'b1;
            core_dv  <= 1'b0;
            ccnt     <= 0;
        end else begin
            core_dv <= 1'b0;
            if (init_o || next_o) begin
                core_rdy <= 1'b0;
                ccnt     <= 65;
            end else if (ccnt == 1) begin
                core_dv  <= 1'b1;
                core_rdy <= 1'b1;
                ccnt     <= 0;
            end else if (ccnt > 1) begin
                ccnt <= ccnt - 1;
            end
        end
    end

    task automatic check(input string tag,
                         input logic [511:0] obs,
                         input logic [511:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] wd(input logic [511:0] b, input int w);
        return b[511-32*w -: 32];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (init_o || next_o) begin
                exp_t e;
                pulses++;
                check("one_hot", init_o & next_o, 0);
                check("queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("block", block_o, e.blk);
                    check("kind_init", init_o, e.first);
                    check("mode", mode_o, e.mode);
                end
                blk_log.push_back(block_o);
            end
            if (msg_done_o) begin
                done_cnt++;
                check("done_with_dv", core_digest_valid_i, 1);
            end
        end
    end

    // Byte-level reference padding of msg, pushed as expected blocks.
    task automatic expect_msg(input bit m);
        byte unsigned     p[$];
        longint unsigned  bits;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 8;
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        for (int b = 0; b < p.size() / 64; b++) begin
            exp_t e;
            e.blk = '0;
            for (int k = 0; k < 64; k++) e.blk[511-8*k -: 8] = p[64*b+k];
            e.first = (b == 0);
            e.mode  = m;
            exp_q.push_back(e);
        end
        done_exp++;
    endtask

    task automatic drive_msg(input bit m, input bit with_last);
        int n;
        int nb;
        n  = msg.size();
        nb = (n == 0) ? 1 : (n + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            logic [31:0] w;
            int          r;
            r = n - 4 * i;
            if (r > 4) r = 4;
            w = $urandom;
            for (int k = 0; k < r; k++) w[31-8*k -: 8] = msg[4*i+k];
            @(negedge clk);
            s_valid_i     = 1'b1;
            s_data_i      = w;
            s_bytes_i     = 3'(r);
            s_last_i      = with_last && (i == nb - 1);
            sha224_mode_i = m;
            for (int t = 0; t < 1000 && !s_ready_o; t++) @(negedge clk);
            check("ready_wait", s_ready_o, 1);
            @(posedge clk);
        end
        @(negedge clk);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 3000 && done_cnt < done_exp; t++) @(negedge clk);
        check("done_count", done_cnt, done_exp);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("idle", {busy_o, s_ready_o}, 2'b01);
    endtask

    task automatic run_msg(input bit m);
        expect_msg(m);
        drive_msg(m, 1'b1);
        check("busy_mid", {busy_o, s_ready_o}, 2'b10);
        wait_done();
    endtask

    task automatic set_str(input string s);
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    endtask

    task automatic set_rand(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    initial begin
        int           base;
        int           p0;
        logic [511:0] b0;
        int           lens[$];

        rst_n         = 1'b0;
        sha224_mode_i = 1'b0;
        s_data_i      = '0;
        s_bytes_i     = '0;
        s_last_i      = 1'b0;
        s_valid_i     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ctl",
              {s_ready_o, init_o, next_o, msg_done_o, busy_o, mode_o},
              6'b100000);
        check("reset_blk", block_o, 0);

        msg.delete();
        run_msg(1'b0);
        check("empty_w0", wd(blk_log[blk_log.size()-1], 0), 32'h8000_0000);
        check("empty_w15", wd(blk_log[blk_log.size()-1], 15), 32'h0);

        set_str("abc");
        run_msg(1'b0);
        check("abc_w0", wd(blk_log[blk_log.size()-1], 0), 32'h6162_6380);
        check("abc_w15", wd(blk_log[blk_log.size()-1], 15), 32'h18);

        run_msg(1'b1);

        set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        base = blk_log.size();
        run_msg(1'b0);
        check("m56_w14", wd(blk_log[base], 14), 32'h8000_0000);
        check("m56_w15", wd(blk_log[base], 15), 32'h0);
        check("m56_b2w0", wd(blk_log[base+1], 0), 32'h0);
        check("m56_b2w15", wd(blk_log[base+1], 15), 32'h1C0);

        set_rand(64);
        base = blk_log.size();
        run_msg(1'b0);
        check("m64_b2w0", wd(blk_log[base+1], 0), 32'h8000_0000);
        check("m64_b2w15", wd(blk_log[base+1], 15), 32'h200);

        hold = 1'b1;
        set_str("abc");
        expect_msg(1'b0);
        drive_msg(1'b0, 1'b1);
        repeat (20) @(negedge clk);
        p0 = pulses;
        b0 = block_o;
        repeat (20) @(negedge clk);
        check("bp_no_pulse", pulses, p0);
        check("bp_stable", block_o, b0);
        hold = 1'b0;
        @(negedge clk);
        check("bp_pulse", init_o, 1);
        wait_done();

        set_rand(20);
        drive_msg(1'b1, 1'b0);
        check("partial_busy", {busy_o, mode_o}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl",
              {s_ready_o, init_o, next_o, msg_done_o, busy_o, mode_o},
              6'b100000);
        check("rst_mid_blk", block_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_str("abc");
        run_msg(1'b0);

        lens = '{1, 2, 4, 5, 52, 53, 55, 57, 59, 60, 61, 63, 65, 119, 120};
        foreach (lens[i]) begin
            set_rand(lens[i]);
            run_msg(1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
